// File: rtl/lb_uart_pkg.sv
// lb_uart_pkg: shared types and helpers for the lb_uart receive path.
//   rx_state_e     receiver FSM states (IDLE, START, DATA, PARITY, STOP)
//   majority3      2-of-3 vote used to filter each oversampled bit
//   MIN_OVERSAMPLE smallest supported oversample ratio
package lb_uart_pkg;

    localparam int MIN_OVERSAMPLE = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/lb_uart_baud_tick.sv
// lb_uart_baud_tick: sample-tick generator for the lb_uart TX/RX cores.
//   clk, reset   system clock, asynchronous active-low reset
//   i_div        clk cycles per tick minus 1 (0 -> tick every clk)
//   i_restart    reload the divider so the next tick lands i_div+1 clk later
//   o_tick       1-clk pulse every i_div+1 clk
module lb_uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] i_div,
    input  logic             i_restart,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;

    // The restart cycle itself never ticks: the phase starts over from it.
    assign o_tick = (r_cnt == '0) && !i_restart;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == '0)) begin
            r_cnt <= i_div;
        end else begin
            r_cnt <= r_cnt - DIV_W'(1);
        end
    end

endmodule

// File: rtl/lb_uart_rx_core.sv
// lb_uart_rx_core: oversampling UART receiver with ready/valid output.
//   clk, reset    system clock, asynchronous active-low reset
//   baud_div      clk cycles per sample tick minus 1; change only while busy=0
//   rx            asynchronous serial input, idle high
//   rx_data       received word, valid while rx_valid
//   rx_valid      word available, held until rx_ready
//   rx_ready      consumer accepts when rx_valid & rx_ready
//   framing_err   a stop bit sampled low (qualified by rx_valid)
//   overrun_err   1-clk pulse when a completed frame is dropped
//   busy          high from start-edge detect until return to IDLE
// Optional feature, macro LB_UART_RX_PARITY_EN: adds parity_en, parity_odd,
// parity_err ports and the PARITY state.
module lb_uart_rx_core
    import lb_uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int DIV_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DIV_W-1:0]     baud_div,
    input  logic                 rx,
`ifdef LB_UART_RX_PARITY_EN
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 framing_err,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_EARLY = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_LATE  = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] B_DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);

    logic                 r_sync1, r_sync2;
    logic                 r_armed;
    rx_state_e            r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [1:0]           r_maj;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr_f;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_framing_err;
    logic                 r_overrun_err;
    logic                 r_busy;
`ifdef LB_UART_RX_PARITY_EN
    logic                 r_par;
    logic                 r_perr_f;
    logic                 r_parity_err;
`endif

    logic          w_rx;
    logic          w_tick;
    logic          w_start;
    logic [TW-1:0] w_tick_idx;
    logic          w_bit_done;
    logic          w_bit_val;
    logic          w_ferr_now;
    logic          w_take;

    assign w_rx       = r_sync2;
    // Armed means rx has been seen high in IDLE, so low here is a real falling edge.
    assign w_start    = (r_state == IDLE) && r_armed && !w_rx;
    // Tick index within the current bit; wrapping to 0 marks a bit boundary.
    assign w_tick_idx = (r_tick_cnt == T_LAST) ? '0 : r_tick_cnt + TW'(1);
    // The third vote arrives on the late tick; the first two are already stored.
    assign w_bit_done = w_tick && (w_tick_idx == T_LATE);
    assign w_bit_val  = majority3(r_maj[0], r_maj[1], w_rx);
    assign w_ferr_now = r_ferr_f | !w_bit_val;
    assign w_take     = !r_rx_valid || rx_ready;

    lb_uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .i_div     (baud_div),
        .i_restart (w_start),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1       <= 1'b1;
            r_sync2       <= 1'b1;
            r_armed       <= 1'b0;
            r_state       <= IDLE;
            r_tick_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_maj         <= '0;
            r_shift       <= '0;
            r_ferr_f      <= 1'b0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_framing_err <= 1'b0;
            r_overrun_err <= 1'b0;
            r_busy        <= 1'b0;
`ifdef LB_UART_RX_PARITY_EN
            r_par         <= 1'b0;
            r_perr_f      <= 1'b0;
            r_parity_err  <= 1'b0;
`endif
        end else begin
            r_sync1       <= rx;
            r_sync2       <= r_sync1;
            r_overrun_err <= 1'b0;

            // Handshake clears valid; a delivery later in this block overrides it.
            if (r_rx_valid && rx_ready)
                r_rx_valid <= 1'b0;

            if (w_tick) begin
                r_tick_cnt <= w_tick_idx;
                if (w_tick_idx == T_EARLY) r_maj[0] <= w_rx;
                if (w_tick_idx == T_MID)   r_maj[1] <= w_rx;
            end

            case (r_state)
                IDLE: begin
                    if (!r_armed) begin
                        r_armed <= w_rx;
                    end else if (!w_rx) begin
                        r_state    <= START;
                        r_busy     <= 1'b1;
                        r_armed    <= 1'b0;
                        r_tick_cnt <= '0;
                        r_ferr_f   <= 1'b0;
`ifdef LB_UART_RX_PARITY_EN
                        r_par      <= 1'b0;
                        r_perr_f   <= 1'b0;
`endif
                    end
                end
                START: begin
                    // Mid-bit high is a glitch; surviving to the boundary confirms the start bit.
                    if (w_tick && (w_tick_idx == T_MID) && w_rx) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_tick && (w_tick_idx == '0)) begin
                        r_state   <= DATA;
                        r_bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (w_bit_done) begin
                        r_shift <= {w_bit_val, r_shift[DATA_BITS-1:1]};
`ifdef LB_UART_RX_PARITY_EN
                        r_par   <= r_par ^ w_bit_val;
`endif
                        if (r_bit_cnt == B_DATA_LAST) begin
                            r_bit_cnt <= '0;
`ifdef LB_UART_RX_PARITY_EN
                            r_state   <= parity_en ? PARITY : STOP;
`else
                            r_state   <= STOP;
`endif
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
`ifdef LB_UART_RX_PARITY_EN
                PARITY: begin
                    if (w_bit_done) begin
                        r_perr_f <= ((r_par ^ w_bit_val) != parity_odd);
                        r_state  <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (w_bit_done) begin
                        if (r_bit_cnt == B_STOP_LAST) begin
                            // Leave at mid-stop so the next start edge is never missed.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                            if (w_take) begin
                                r_rx_data     <= r_shift;
                                r_framing_err <= w_ferr_now;
`ifdef LB_UART_RX_PARITY_EN
                                r_parity_err  <= r_perr_f;
`endif
                                r_rx_valid    <= 1'b1;
                            end else begin
                                r_overrun_err <= 1'b1;
                            end
                        end else begin
                            r_ferr_f  <= w_ferr_now;
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign framing_err = r_framing_err;
    assign overrun_err = r_overrun_err;
    assign busy        = r_busy;
`ifdef LB_UART_RX_PARITY_EN
    assign parity_err  = r_parity_err;
`endif

endmodule

// File: tb/tb_lb_uart_rx_core.sv
// Bench for lb_uart_rx_core (8 data bits, 1 stop bit, OVERSAMPLE=16, baud_div=3).
// The model is a queue of expected words derived from the frames the bench sends;
// one negedge process checks every accepted word, held-word stability and overrun pulses.
module tb_lb_uart_rx_core;

    localparam int OS   = 16;
    localparam int DIV  = 3;
    localparam int BIT  = OS * (DIV + 1);
    // Start edge to rx_valid: 9.5 bit times plus synchroniser, within about one tick.
    localparam int EXP_LAT = (OS * 10 - OS / 2) * (DIV + 1) + 3;
    localparam int LAT_TOL = 2 * (DIV + 1);

    typedef struct {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] baud_div;
    logic        rx;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        framing_err;
    logic        overrun_err;
    logic        busy;
    logic        par_en;
    logic        par_odd;
`ifdef LB_UART_RX_PARITY_EN
    logic        parity_err;
`endif

    lb_uart_rx_core dut (
        .clk         (clk),
        .reset       (reset),
        .baud_div    (baud_div),
        .rx          (rx),
`ifdef LB_UART_RX_PARITY_EN
        .parity_en   (par_en),
        .parity_odd  (par_odd),
        .parity_err  (parity_err),
`endif
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .framing_err (framing_err),
        .overrun_err (overrun_err),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   exp_ov = 0;
    int   ov_seen = 0;
    int   n_acc = 0;
    int   edge_cyc = 0;
    int   rise_cyc = 0;
    logic [7:0] last_data = '0;
    logic       last_ferr = 1'b0;
    logic       last_perr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic logic exp_perr(input logic [7:0] d, input logic pb);
        return par_en && (((^d) ^ pb) != par_odd);
    endfunction

    // Compare process
    logic       p_valid = 1'b0;
    logic       p_ready = 1'b0;
    logic       p_ov = 1'b0;
    logic [7:0] p_data = '0;

    always @(negedge clk) begin
        if (!reset) begin
            p_valid <= 1'b0;
            p_ready <= 1'b0;
            p_ov    <= 1'b0;
        end else begin
            if (rx_valid && !p_valid)
                rise_cyc <= cyc;
            if (p_valid && !p_ready) begin
                check("hold_valid", rx_valid, 1);
                check("hold_data", rx_data, p_data);
            end
            if (overrun_err) begin
                ov_seen++;
                check("overrun_pulse_width", p_ov, 0);
            end
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("word_data", rx_data, e.data);
                    check("word_framing_err", framing_err, e.ferr);
`ifdef LB_UART_RX_PARITY_EN
                    check("word_parity_err", parity_err, e.perr);
                    last_perr <= parity_err;
`endif
                    last_data <= rx_data;
                    last_ferr <= framing_err;
                    n_acc++;
                end
            end
            p_valid <= rx_valid;
            p_ready <= rx_ready;
            p_ov    <= overrun_err;
            p_data  <= rx_data;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive n bit periods from bits[0..n-1]; optionally invert one tick-wide
    // window (clk 32..35 of that bit, i.e. only the tick-8 sample) in bit 'glitch'.
    task automatic drive_bits(input logic [15:0] bits, input int n, input int glitch);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < BIT; c++) begin
                rx = bits[i] ^ ((i == glitch) && (c >= 32) && (c < 36));
                if ((i == 0) && (c == 0)) edge_cyc = cyc;
                step(1);
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic pb,
                              input int glitch_data_bit, input bit idle_after);
        logic [15:0] b;
        int          n;
        exp_t        e;
        b = '0;
        for (int j = 0; j < 8; j++) b[1 + j] = d[j];
        n = 9;
        if (par_en) begin
            b[n] = pb;
            n++;
        end
        b[n] = stop_v;
        n++;
        e.data = d;
        e.ferr = !stop_v;
        e.perr = exp_perr(d, pb);
        // A word still waiting when ready is low means this frame is dropped.
        if (!rx_ready && (exp_q.size() > 0)) exp_ov++;
        else exp_q.push_back(e);
        drive_bits(b, n, (glitch_data_bit < 0) ? -1 : glitch_data_bit + 1);
        if (idle_after) begin
            rx = 1'b1;
            step(BIT);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n_before;
        reset = 1'b0; rx = 1'b1; rx_ready = 1'b1; baud_div = 16'(DIV);
        par_en = 1'b0; par_odd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_rx_data", rx_data, 0);
        check("reset_framing_err", framing_err, 0);
        check("reset_overrun_err", overrun_err, 0);
        check("reset_busy", busy, 0);
`ifdef LB_UART_RX_PARITY_EN
        check("reset_parity_err", parity_err, 0);
`endif
        @(posedge clk); #1;
        reset = 1'b1;
        step(5);
        check("busy_after_reset", busy, 0);

        // Plain 8N1 frame
        send_frame(8'hA5, 1'b1, 1'b0, -1, 1);
        lat = rise_cyc - edge_cyc;
        check("latency_window", ((lat >= EXP_LAT - LAT_TOL) && (lat <= EXP_LAT + LAT_TOL)) ? 1 : 0, 1);
        check("a5_data_literal", last_data, 8'hA5);
        check("a5_ferr_literal", last_ferr, 0);
        check("a5_busy_done", busy, 0);

        // False start: low for 3 ticks
        rx = 1'b0;
        step(12);
        rx = 1'b1;
        step(8);
        check("false_start_busy_high", busy, 1);
        step(20);
        check("false_start_busy_low", busy, 0);
        check("false_start_no_word", n_acc, 1);
        step(BIT);
        send_frame(8'h3C, 1'b1, 1'b0, -1, 1);
        check("3c_data_literal", last_data, 8'h3C);

        // One-tick glitch on data bit 2 of 0x00
        send_frame(8'h00, 1'b1, 1'b0, 2, 1);
        check("glitch_data_literal", last_data, 8'h00);

        // Stop bit low, then rx held low (break guard)
        send_frame(8'h55, 1'b0, 1'b0, -1, 0);
        n_before = n_acc;
        step(2 * BIT);
        check("break_data_literal", last_data, 8'h55);
        check("break_ferr_literal", last_ferr, 1);
        check("break_no_restart", busy, 0);
        check("break_no_new_word", n_acc - n_before, 0);
        rx = 1'b1;
        step(BIT);
        send_frame(8'hC3, 1'b1, 1'b0, -1, 1);
        check("after_break_data", last_data, 8'hC3);
        check("after_break_ferr", last_ferr, 0);

        // Overrun: consumer stalled across two frames
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0, -1, 1);
        send_frame(8'h22, 1'b1, 1'b0, -1, 1);
        check("ovr_held_data", rx_data, 8'h11);
        check("ovr_valid_held", rx_valid, 1);
        check("ovr_one_pulse", ov_seen, 1);
        rx_ready = 1'b1;
        step(2);
        check("ovr_accept_literal", last_data, 8'h11);
        check("ovr_valid_cleared", rx_valid, 0);

`ifdef LB_UART_RX_PARITY_EN
        par_en = 1'b1; par_odd = 1'b1;
        send_frame(8'h07, 1'b1, 1'b1, -1, 1);
        check("parity_bad_literal", last_perr, 1);
        send_frame(8'h07, 1'b1, 1'b0, -1, 1);
        check("parity_good_literal", last_perr, 0);
        par_en = 1'b0; par_odd = 1'b0;
`endif

        // Reset mid-DATA while an old word is held
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0, -1, 1);
        drive_bits(16'b0000_0000_0000_1110, 4, -1);
        reset = 1'b0;
        exp_q.delete();
        step(2);
        @(negedge clk);
        check("midreset_rx_valid", rx_valid, 0);
        check("midreset_rx_data", rx_data, 0);
        check("midreset_framing_err", framing_err, 0);
        check("midreset_overrun_err", overrun_err, 0);
        check("midreset_busy", busy, 0);
`ifdef LB_UART_RX_PARITY_EN
        check("midreset_parity_err", parity_err, 0);
`endif
        rx = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        rx_ready = 1'b1;
        step(2 * BIT);
        check("post_reset_idle", rx_valid, 0);
        send_frame(8'h96, 1'b1, 1'b0, -1, 1);
        check("post_reset_data", last_data, 8'h96);
        check("post_reset_ferr", last_ferr, 0);

        for (int k = 0; (k < 1000) && (exp_q.size() > 0); k++) step(1);
        check("queue_drained", exp_q.size(), 0);
        check("overrun_total", ov_seen, exp_ov);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
